// File: rtl/uart_rx_parity_engine.sv
// ============================================================================
// uart_rx_parity_engine
// ----------------------------------------------------------------------------
// Serial parity engine for the UART receive path. It sits between the data
// sampler and the RX FSM. Parity is accumulated one bit at a time as the
// sampler strobes data bits in (LSB first). The received parity bit is then
// checked against the expected value for the configured mode.
//
// Parameters
//   BUS_WIDTH  maximum data bits per frame (>= 1)
//   CNT_WIDTH  width of the saturating parity-error counter (>= 1)
//   LEN_WIDTH  width of DATA_LEN; derived from BUS_WIDTH, leave at default
//
// Ports
//   CLK          in   clock, all logic on the rising edge
//   RST          in   synchronous reset, active low
//   FRAME_START  in   start bit validated: (re)arms the engine, latches config
//   DATA_LEN     in   data bits per frame, clamped to 1..BUS_WIDTH on latch
//   PAR_MODE     in   0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none
//   BIT_VALID    in   SAMPLED_BIT is valid this cycle (one strobe per bit)
//   SAMPLED_BIT  in   serial bit: data LSB first, then the parity bit
//   ERR_CLR      in   clears ERR_STICKY and ERR_CNT
//   PAR_DONE     out  one-cycle pulse when a frame check completes
//   PAR_ERR      out  result of the last completed frame, held until the
//                     next FRAME_START
//   CALC_PAR     out  XOR of the data bits of the last completed frame
//   ERR_STICKY   out  set on any parity error, cleared by ERR_CLR
//   ERR_CNT      out  parity errors since the last clear, saturating
// ============================================================================
module uart_rx_parity_engine #(
  parameter int BUS_WIDTH = 9,
  parameter int CNT_WIDTH = 8,
  parameter int LEN_WIDTH = $clog2(BUS_WIDTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FRAME_START,
  input  logic [LEN_WIDTH-1:0] DATA_LEN,
  input  logic [2:0]           PAR_MODE,
  input  logic                 BIT_VALID,
  input  logic                 SAMPLED_BIT,
  input  logic                 ERR_CLR,
  output logic                 PAR_DONE,
  output logic                 PAR_ERR,
  output logic                 CALC_PAR,
  output logic                 ERR_STICKY,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M_NONE  = 3'd0,
    M_EVEN  = 3'd1,
    M_ODD   = 3'd2,
    M_MARK  = 3'd3,
    M_SPACE = 3'd4
  } mode_t;

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------

  // Frame length is forced into 1..BUS_WIDTH so the bit counter always has a
  // reachable terminal value.
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
    if (len == '0) begin
      return LEN_WIDTH'(1);
    end else if (len > LEN_WIDTH'(BUS_WIDTH)) begin
      return LEN_WIDTH'(BUS_WIDTH);
    end else begin
      return len;
    end
  endfunction

  // Reserved encodings 5-7 behave as "no parity".
  function automatic mode_t map_mode(input logic [2:0] mode);
    case (mode)
      3'd1:    return M_EVEN;
      3'd2:    return M_ODD;
      3'd3:    return M_MARK;
      3'd4:    return M_SPACE;
      default: return M_NONE;
    endcase
  endfunction

  // Value the parity bit must carry, given the XOR of the data bits.
  function automatic logic expected_parity(input mode_t mode, input logic acc);
    case (mode)
      M_EVEN:  return acc;
      M_ODD:   return ~acc;
      M_MARK:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Next value of the error counter: saturate at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (cnt == '1) begin
      return cnt;
    end else begin
      return cnt + CNT_WIDTH'(1);
    end
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                 state_q,  state_nxt;
  mode_t                  mode_q,   mode_nxt;
  logic [LEN_WIDTH-1:0]   len_q,    len_nxt;
  logic [LEN_WIDTH-1:0]   bcnt_q,   bcnt_nxt;
  logic                   acc_q,    acc_nxt;
  logic                   done_nxt;
  logic                   err_nxt;
  logic                   calc_nxt;
  logic                   sticky_nxt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   last_data_bit;
  logic                   acc_upd;

  assign last_data_bit = (bcnt_q == (len_q - LEN_WIDTH'(1)));
  assign acc_upd       = acc_q ^ SAMPLED_BIT;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      mode_q     <= M_NONE;
      len_q      <= LEN_WIDTH'(1);
      bcnt_q     <= '0;
      acc_q      <= 1'b0;
      PAR_DONE   <= 1'b0;
      PAR_ERR    <= 1'b0;
      CALC_PAR   <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_CNT    <= '0;
    end else begin
      state_q    <= state_nxt;
      mode_q     <= mode_nxt;
      len_q      <= len_nxt;
      bcnt_q     <= bcnt_nxt;
      acc_q      <= acc_nxt;
      PAR_DONE   <= done_nxt;
      PAR_ERR    <= err_nxt;
      CALC_PAR   <= calc_nxt;
      ERR_STICKY <= sticky_nxt;
      ERR_CNT    <= cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    mode_nxt  = mode_q;
    len_nxt   = len_q;
    bcnt_nxt  = bcnt_q;
    acc_nxt   = acc_q;
    done_nxt  = 1'b0;
    err_nxt   = PAR_ERR;
    calc_nxt  = CALC_PAR;

    if (FRAME_START) begin
      // Start has priority over everything: it aborts any frame in flight
      // without reporting it, and a strobe in the same cycle is discarded.
      state_nxt = S_DATA;
      mode_nxt  = map_mode(PAR_MODE);
      len_nxt   = clamp_len(DATA_LEN);
      bcnt_nxt  = '0;
      acc_nxt   = 1'b0;
      err_nxt   = 1'b0;
    end else if (BIT_VALID) begin
      case (state_q)
        S_IDLE: begin
        end
        S_DATA: begin
          acc_nxt  = acc_upd;
          bcnt_nxt = bcnt_q + LEN_WIDTH'(1);
          if (last_data_bit) begin
            if (mode_q == M_NONE) begin
              // No parity bit follows; the frame completes on its last data bit.
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
              err_nxt   = 1'b0;
              calc_nxt  = acc_upd;
            end else begin
              state_nxt = S_PARITY;
            end
          end
        end
        S_PARITY: begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          err_nxt   = (SAMPLED_BIT != expected_parity(mode_q, acc_q));
          calc_nxt  = acc_q;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Error statistics. A fresh error on the same edge as ERR_CLR is kept: the
  // clear wipes the old history and the new error becomes the first count.
  always_comb begin
    sticky_nxt = ERR_STICKY;
    cnt_nxt    = ERR_CNT;
    if (done_nxt && err_nxt) begin
      sticky_nxt = 1'b1;
      cnt_nxt    = ERR_CLR ? CNT_WIDTH'(1) : sat_inc(ERR_CNT);
    end else if (ERR_CLR) begin
      sticky_nxt = 1'b0;
      cnt_nxt    = '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_parity_engine.sv
// ============================================================================
// tb_uart_rx_parity_engine
// ----------------------------------------------------------------------------
// Self-checking bench for uart_rx_parity_engine. Frames are described at the
// protocol level (length, mode, data word, parity bit) and the expected
// result is computed directly from the parity rules. A small error-statistics
// model tracks the sticky flag and saturating counter.
// ============================================================================
module tb_uart_rx_parity_engine;

  localparam int BW     = 9;
  localparam int CW     = 2;
  localparam int LW     = $clog2(BW + 1);
  localparam int CNTMAX = (1 << CW) - 1;

  logic          CLK         = 1'b0;
  logic          RST         = 1'b0;
  logic          FRAME_START = 1'b0;
  logic [LW-1:0] DATA_LEN    = '0;
  logic [2:0]    PAR_MODE    = '0;
  logic          BIT_VALID   = 1'b0;
  logic          SAMPLED_BIT = 1'b0;
  logic          ERR_CLR     = 1'b0;
  logic          PAR_DONE;
  logic          PAR_ERR;
  logic          CALC_PAR;
  logic          ERR_STICKY;
  logic [CW-1:0] ERR_CNT;

  int total      = 0;
  int bad        = 0;
  int done_seen  = 0;
  int exp_sticky = 0;
  int exp_cnt    = 0;
  int last_err   = 0;
  int last_calc  = 0;

  uart_rx_parity_engine #(
    .BUS_WIDTH (BW),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FRAME_START (FRAME_START),
    .DATA_LEN    (DATA_LEN),
    .PAR_MODE    (PAR_MODE),
    .BIT_VALID   (BIT_VALID),
    .SAMPLED_BIT (SAMPLED_BIT),
    .ERR_CLR     (ERR_CLR),
    .PAR_DONE    (PAR_DONE),
    .PAR_ERR     (PAR_ERR),
    .CALC_PAR    (CALC_PAR),
    .ERR_STICKY  (ERR_STICKY),
    .ERR_CNT     (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Count completion pulses; a pulse spans one full cycle so each is seen once.
  always @(negedge CLK) begin
    if (PAR_DONE === 1'b1) done_seen++;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int done_exp);
    check_val({tag, ".done"},   32'(PAR_DONE),   32'(done_exp));
    check_val({tag, ".err"},    32'(PAR_ERR),    32'(last_err));
    check_val({tag, ".calc"},   32'(CALC_PAR),   32'(last_calc));
    check_val({tag, ".sticky"}, 32'(ERR_STICKY), 32'(exp_sticky));
    check_val({tag, ".cnt"},    32'(ERR_CNT),    32'(exp_cnt));
  endtask

  function automatic int clamp_len(input int len_raw);
    if (len_raw < 1) return 1;
    if (len_raw > BW) return BW;
    return len_raw;
  endfunction

  task automatic start_frame(input int len_raw, input int mode, input bit collide);
    FRAME_START = 1'b1;
    DATA_LEN    = LW'(len_raw);
    PAR_MODE    = 3'(mode);
    BIT_VALID   = collide;
    SAMPLED_BIT = 1'b1;
    tick;
    FRAME_START = 1'b0;
    BIT_VALID   = 1'b0;
    DATA_LEN    = LW'($urandom);
    PAR_MODE    = 3'($urandom);
  endtask

  task automatic send_bit(input bit b, input bit clr);
    repeat ($urandom_range(0, 2)) tick;
    BIT_VALID   = 1'b1;
    SAMPLED_BIT = b;
    ERR_CLR     = clr;
    tick;
    BIT_VALID   = 1'b0;
    ERR_CLR     = 1'b0;
  endtask

  task automatic clear_errs(input string tag);
    ERR_CLR = 1'b1;
    tick;
    ERR_CLR    = 1'b0;
    exp_sticky = 0;
    exp_cnt    = 0;
    check_val({tag, ".sticky"}, 32'(ERR_STICKY), 0);
    check_val({tag, ".cnt"},    32'(ERR_CNT),    0);
  endtask

  // One complete frame, optionally preceded by an aborted partial frame
  // (ab_bits >= 0) and optionally with a strobe colliding with FRAME_START.
  task automatic run_frame(input string tag, input int len_raw, input int mode,
                           input logic [15:0] data, input bit pbit, input bit clr_last,
                           input bit collide, input int ab_len, input int ab_mode,
                           input int ab_bits);
    int len;
    int d0;
    bit has_par;
    bit err;
    bit calc;
    len  = clamp_len(len_raw);
    calc = 1'b0;
    for (int i = 0; i < len; i++) calc ^= data[i];
    has_par = 1'b1;
    case (mode)
      1:       err = (pbit != calc);
      2:       err = (pbit != !calc);
      3:       err = (pbit != 1'b1);
      4:       err = (pbit != 1'b0);
      default: begin has_par = 1'b0; err = 1'b0; end
    endcase

    d0 = done_seen;
    if (ab_bits >= 0) begin
      start_frame(ab_len, ab_mode, 1'b0);
      for (int k = 0; k < ab_bits; k++) send_bit(1'($urandom), 1'b0);
    end
    start_frame(len_raw, mode, collide);
    for (int i = 0; i < len; i++) send_bit(data[i], clr_last && !has_par && (i == len - 1));
    if (has_par) send_bit(pbit, clr_last);

    last_err  = err;
    last_calc = calc;
    if (err) begin
      exp_sticky = 1;
      exp_cnt    = clr_last ? 1 : ((exp_cnt < CNTMAX) ? exp_cnt + 1 : CNTMAX);
    end else if (clr_last) begin
      exp_sticky = 0;
      exp_cnt    = 0;
    end
    check_outputs(tag, 1);
    tick;
    check_outputs({tag, ".hold"}, 0);
    check_val({tag, ".pulses"}, 32'(done_seen - d0), 1);
  endtask

  initial begin
    int d0;
    int ab;
    int abl;
    int abm;

    // Power-up reset
    RST = 1'b0;
    tick;
    tick;
    RST = 1'b1;
    check_outputs("reset", 0);

    // Directed frames
    run_frame("even_a5_ok",  8, 1, 16'h00A5, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_frame("even_a5_bad", 8, 1, 16'h00A5, 1'b1, 1'b0, 1'b0, 0, 0, -1);

    // Reset in the middle of a frame
    start_frame(8, 1, 1'b0);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
    RST = 1'b0;
    tick;
    tick;
    RST        = 1'b1;
    exp_sticky = 0;
    exp_cnt    = 0;
    last_err   = 0;
    last_calc  = 0;
    check_outputs("midreset", 0);
    d0 = done_seen;
    for (int k = 0; k < 10; k++) send_bit(1'($urandom), 1'b0);
    tick;
    check_val("midreset.ignored", 32'(done_seen - d0), 0);
    check_outputs("midreset.idle", 0);

    run_frame("odd_01",      7, 2, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_frame("mark_bad",    5, 3, 16'h0015, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_frame("space_ok",    5, 4, 16'h000B, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_frame("none_mode6",  8, 6, 16'h00C7, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_frame("clamp_lo",    0, 1, 16'h0001, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_frame("clamp_hi",   15, 1, 16'h0100, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_frame("clamp_hi2",  15, 2, 16'hFF00, 1'b1, 1'b0, 1'b0, 0, 0, -1);

    // Abort after 4 of 8 bits, then a good even frame
    run_frame("abort",       8, 1, 16'h003C, 1'b0, 1'b0, 1'b0, 8, 1, 4);
    // Strobe coinciding with FRAME_START must be dropped
    run_frame("collide",     4, 1, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, -1);
    run_frame("collide2",    3, 2, 16'h0005, 1'b1, 1'b0, 1'b1, 0, 0, -1);

    // Counter saturation and clearing
    clear_errs("clr0");
    for (int n = 0; n < 5; n++) run_frame("sat", 5, 3, 16'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, -1);
    check_val("sat.cnt_final", 32'(ERR_CNT), 32'(CNTMAX));
    run_frame("clr_with_err", 5, 3, 16'h0003, 1'b0, 1'b1, 1'b0, 0, 0, -1);
    check_val("clr_with_err.cnt", 32'(ERR_CNT), 1);
    clear_errs("clr1");

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      abl = int'($urandom_range(0, 15));
      abm = int'($urandom_range(0, 7));
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, clamp_len(abl) - 1)) : -1;
      run_frame("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                16'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), abl, abm, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
